// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush/redirect controller: merges stage stall requests into a stall mask,
// turns MEM exceptions into a flush of FLUSH_CYCLES cycles plus a PC redirect, and runs a stall watchdog.
module pipe_ctrl_gen #(
  parameter int                NUM_STAGES    = 6,
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] INT_VECTOR    = 'h20,
  parameter logic [ADDR_W-1:0] EXC_VECTOR    = 'h40,
  parameter int                FLUSH_CYCLES  = 1,
  parameter int                STALL_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq_i,
  input  logic [31:0]           excepttype_i,
  input  logic [ADDR_W-1:0]     cp0_epc_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic                  flush_o,
  output logic [ADDR_W-1:0]     new_pc_o,
  output logic                  new_pc_vld_o,
  output logic                  stall_timeout_o,
  output logic [15:0]           stall_cnt_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  localparam int                CNT_W        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) + 1 : 1;
  localparam logic [CNT_W-1:0]  FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam bit                TO_EN        = (STALL_TIMEOUT > 0);
  localparam logic [31:0]       TO_LIM       = TO_EN ? 32'(STALL_TIMEOUT - 1) : 32'd0;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  exc, in_flush, stalled;
  logic [NUM_STAGES-1:0] req_mask;

  function automatic logic [ADDR_W-1:0] redirect_target(input logic [31:0]       etype,
                                                        input logic [ADDR_W-1:0] epc);
    case (etype)
      32'h1:                redirect_target = INT_VECTOR;
      32'he:                redirect_target = epc;
      32'h8, 32'ha, 32'hd:  redirect_target = EXC_VECTOR;
      default:              redirect_target = EXC_VECTOR;
    endcase
  endfunction

  // Stage j holds whenever any stage at or above it (k>=1) requests a pause; the PC bit never requests.
  always_comb begin : mask_gen
    logic acc;
    acc      = 1'b0;
    req_mask = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      acc         = acc | (stallreq_i[k] & (k != 0));
      req_mask[k] = acc;
    end
  end

  assign exc      = |excepttype_i;
  assign in_flush = (state_q == S_FLUSH);

  // Outputs are gated by rst so they read 0 for the whole reset interval, combinational paths included.
  assign flush_o         = rst & (exc | in_flush);
  assign new_pc_vld_o    = rst & exc;
  assign new_pc_o        = (rst & exc) ? redirect_target(excepttype_i, cp0_epc_i) : '0;
  assign stall_o         = (rst & ~exc & ~in_flush) ? req_mask : '0;
  assign stall_timeout_o = timeout_q;
  assign stall_cnt_o     = stall_cnt_q;
  assign stalled         = |stall_o;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (exc) begin
      if (FLUSH_CYCLES > 1) begin
        state_d     = S_FLUSH;
        flush_cnt_d = FLUSH_RELOAD;
      end else begin
        state_d     = S_IDLE;
        flush_cnt_d = '0;
      end
    end else if (in_flush) begin
      flush_cnt_d = flush_cnt_q - CNT_W'(1);
      if (flush_cnt_q == CNT_W'(1)) state_d = S_IDLE;
    end
  end

  always_comb begin
    stall_cnt_d = '0;
    timeout_d   = 1'b0;
    if (stalled) begin
      stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
      timeout_d   = (TO_EN && ({16'd0, stall_cnt_d} >= TO_LIM)) ? 1'b1 : timeout_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Bench for pipe_ctrl_gen (FLUSH_CYCLES=3, STALL_TIMEOUT=4): vector table, corner sequences, random vs. model.
module tb_pipe_ctrl_gen;
  localparam int FC = 3;
  localparam int ST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallreq;
  logic [31:0] exctype;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush, vld, tout;
  logic [31:0] new_pc;
  logic [15:0] scnt;

  int total = 0;
  int passed = 0;
  int flush_rem = 0;
  int run = 0;

  pipe_ctrl_gen #(.NUM_STAGES(6), .ADDR_W(32), .INT_VECTOR(32'h20), .EXC_VECTOR(32'h40),
                  .FLUSH_CYCLES(FC), .STALL_TIMEOUT(ST)) dut (
    .clk(clk), .rst(rst), .stallreq_i(stallreq), .excepttype_i(exctype), .cp0_epc_i(epc),
    .stall_o(stall), .flush_o(flush), .new_pc_o(new_pc), .new_pc_vld_o(vld),
    .stall_timeout_o(tout), .stall_cnt_o(scnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  req;
    logic [31:0] et;
    logic [31:0] ep;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    else passed++;
  endtask

  function automatic logic [5:0] ref_mask(input logic [5:0] r);
    int h = -1;
    for (int k = 1; k < 6; k++) if (r[k]) h = k;
    return (h < 0) ? 6'd0 : 6'((1 << (h + 1)) - 1);
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] t, input logic [31:0] e);
    if (t == 32'h1) return 32'h20;
    if (t == 32'he) return e;
    return 32'h40;
  endfunction

  function automatic logic [5:0] exp_stall();
    return (exctype != 0 || flush_rem > 0) ? 6'd0 : ref_mask(stallreq);
  endfunction

  // Advance one clock: update the model with this cycle's inputs, return at the next negedge.
  task automatic adv();
    logic st;
    st = (exp_stall() != 0);
    @(posedge clk);
    run = st ? run + 1 : 0;
    if (exctype != 0) flush_rem = FC - 1;
    else if (flush_rem > 0) flush_rem--;
    @(negedge clk);
  endtask

  task automatic tick();
    logic ex;
    ex = (exctype != 0);
    #2;
    chk("m_stall", stall, exp_stall());
    chk("m_flush", flush, ex || flush_rem > 0);
    chk("m_vld", vld, ex);
    chk("m_pc", new_pc, ex ? ref_target(exctype, epc) : 32'd0);
    chk("m_cnt", scnt, (run > 65535) ? 65535 : run);
    chk("m_tout", tout, run > 0 && run >= ST - 1);
    adv();
  endtask

  task automatic idle(input int n);
    stallreq = '0; exctype = '0; epc = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [31:0] types[7];

  initial begin
    tbl[0]  = '{6'b001000, 32'h0, 32'h0,    6'b001111, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{6'b000100, 32'h0, 32'h0,    6'b000111, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{6'b001100, 32'h0, 32'h0,    6'b001111, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{6'b000001, 32'h0, 32'h0,    6'b000000, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{6'b100000, 32'h0, 32'h0,    6'b111111, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{6'b000011, 32'h0, 32'h0,    6'b000011, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{6'b001000, 32'h1, 32'h0,    6'b000000, 1'b1, 1'b1, 32'h20};
    tbl[7]  = '{6'b000000, 32'he, 32'h1234, 6'b000000, 1'b1, 1'b1, 32'h1234};
    tbl[8]  = '{6'b000000, 32'h7, 32'h0,    6'b000000, 1'b1, 1'b1, 32'h40};
    tbl[9]  = '{6'b010000, 32'h8, 32'h0,    6'b000000, 1'b1, 1'b1, 32'h40};
    tbl[10] = '{6'b000000, 32'ha, 32'h99,   6'b000000, 1'b1, 1'b1, 32'h40};
    tbl[11] = '{6'b000100, 32'hd, 32'h0,    6'b000000, 1'b1, 1'b1, 32'h40};
    types = '{32'h1, 32'h8, 32'ha, 32'hd, 32'he, 32'h7, 32'h0};

    // Reset with busy inputs: every output must still read 0.
    rst = 1'b0; stallreq = 6'h3f; exctype = 32'h1; epc = 32'h55;
    @(negedge clk); #1;
    chk("rst_stall", stall, 0); chk("rst_flush", flush, 0); chk("rst_vld", vld, 0);
    chk("rst_pc", new_pc, 0);   chk("rst_tout", tout, 0);   chk("rst_cnt", scnt, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    for (int i = 0; i < 12; i++) begin
      stallreq = tbl[i].req; exctype = tbl[i].et; epc = tbl[i].ep;
      #2;
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_flush", i), flush, tbl[i].e_flush);
      chk($sformatf("tbl%0d_vld", i), vld, tbl[i].e_vld);
      chk($sformatf("tbl%0d_pc", i), new_pc, tbl[i].e_pc);
      adv();
      idle(4);
    end

    // Single exception: flush exactly 3 cycles, strobe only in the first.
    stallreq = 6'b001000; exctype = 32'h8; #2;
    chk("fl1_flush", flush, 1); chk("fl1_vld", vld, 1);
    adv(); exctype = 0;
    for (int c = 2; c <= 4; c++) begin
      #2;
      chk($sformatf("fl%0d_flush", c), flush, c <= 3);
      chk($sformatf("fl%0d_vld", c), vld, 0);
      chk($sformatf("fl%0d_stall", c), stall, (c <= 3) ? 6'b0 : 6'b001111);
      adv();
    end
    idle(4);

    // Second exception in cycle 2 extends the flush to cycle 4 with a second strobe.
    exctype = 32'h8; #2; chk("fx1_vld", vld, 1); adv();
    exctype = 32'h1; #2; chk("fx2_vld", vld, 1); chk("fx2_pc", new_pc, 32'h20); adv();
    exctype = 0;
    for (int c = 3; c <= 5; c++) begin
      #2;
      chk($sformatf("fx%0d_flush", c), flush, c <= 4);
      chk($sformatf("fx%0d_vld", c), vld, 0);
      adv();
    end
    idle(3);

    // Watchdog: stage 4 held for 6 cycles, then released.
    stallreq = 6'b010000;
    for (int c = 1; c <= 8; c++) begin
      if (c == 7) stallreq = 6'b0;
      #2;
      chk($sformatf("wd%0d_tout", c), tout, c >= 4 && c <= 7);
      chk($sformatf("wd%0d_cnt", c), scnt, (c <= 7) ? c - 1 : 0);
      adv();
    end
    idle(2);

    // Reset asserted mid-flush aborts at once.
    exctype = 32'h8; #2; chk("rf1_flush", flush, 1); adv();
    exctype = 32'h1; stallreq = 6'h3f; rst = 1'b0; #1;
    chk("rf_flush", flush, 0); chk("rf_vld", vld, 0); chk("rf_pc", new_pc, 0); chk("rf_stall", stall, 0);
    @(negedge clk); #1;
    chk("rf_hold_flush", flush, 0);
    @(negedge clk);
    rst = 1'b1; exctype = 0; stallreq = 0; flush_rem = 0; run = 0;
    #2; chk("rf_rel_flush", flush, 0); chk("rf_rel_stall", stall, 0);
    adv();

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0)
        stallreq = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
      exctype = ($urandom_range(0, 9) == 0) ? types[$urandom_range(0, 5)] : 32'd0;
      if (exctype == 32'h7 && $urandom_range(0, 1) == 1) exctype = $urandom | 32'h100;
      epc = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
